// File: rtl/store_buffer_pkg.sv
// Shared types and default sizing for the store buffer.
// State encoding and parameter defaults are common to the top and its comparator.
package store_buffer_pkg;
  localparam int SB_DEPTH  = 4;
  localparam int SB_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    ACTIVE   = 2'd1,
    FLUSHING = 2'd2
  } sb_state_e;
endpackage

// File: rtl/store_buffer_if.sv
// CPU-side load/store signals and data-memory port of the store buffer.
// The slave modport is the buffer's view; the master modport is the CPU/memory side.
import store_buffer_pkg::*;

interface store_buffer_if #(parameter int DATA_W = SB_DATA_W);
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              flush;
  logic [DATA_W-1:0] read_data;
  logic              stall;
  logic              dm_read;
  logic              dm_write;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_write_data;
  logic [DATA_W-1:0] dm_read_data;

  modport slave (
    input  mem_read, mem_write, addr, write_data, flush, dm_read_data,
    output read_data, stall, dm_read, dm_write, dm_addr, dm_write_data
  );

  modport master (
    output mem_read, mem_write, addr, write_data, flush, dm_read_data,
    input  read_data, stall, dm_read, dm_write, dm_addr, dm_write_data
  );
endinterface

// File: rtl/store_buffer_match.sv
// Store-to-load forwarding lookup: compares a load address against every valid
// entry and picks the youngest hit, walking backwards from the slot before tail.
import store_buffer_pkg::*;

module store_buffer_match #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = SB_DATA_W,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] data_i,
  input  logic [PW-1:0]                tail_i,
  input  logic [DATA_W-1:0]            lookup_i,
  output logic                         hit_o,
  output logic [DATA_W-1:0]            data_o
);
  logic [DEPTH-1:0] eq;
  logic [PW-1:0]    idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign eq[g] = valid_i[g] && (addr_i[g] == lookup_i);
  end

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_i - PW'(i + 1);
      if (!hit_o && eq[idx]) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer: circular FIFO of {addr,data} with load forwarding,
// drain to data memory when the port is idle, and a flush mode that empties it.
import store_buffer_pkg::*;

module store_buffer #(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = SB_DATA_W
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_state_e                    state_q;
  logic [PW-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]                count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][DATA_W-1:0] addr_q, data_q;

  logic              flush_act, full, load, store, enq, ld_miss, drain, hit;
  logic [DATA_W-1:0] hit_data;

  store_buffer_match #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_match (
    .valid_i  (valid_q),
    .addr_i   (addr_q),
    .data_i   (data_q),
    .tail_i   (tail_q),
    .lookup_i (bus.addr),
    .hit_o    (hit),
    .data_o   (hit_data)
  );

  // A flush request with work pending behaves like FLUSHING in its own cycle.
  always_comb begin
    flush_act = (state_q == FLUSHING) || (bus.flush && (count_q != '0));
    full      = (count_q == CW'(DEPTH));
    load      = bus.mem_read  && !flush_act;
    store     = bus.mem_write && !flush_act;
    enq       = store && !full;
    ld_miss   = load && !hit;
    drain     = !ld_miss && (count_q != '0);

    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = enq   ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(enq) - CW'(drain);
    valid_d = valid_q;
    if (drain) valid_d[head_q] = 1'b0;
    if (enq)   valid_d[tail_q] = 1'b1;
  end

  always_comb begin
    bus.read_data     = '0;
    bus.stall         = 1'b0;
    bus.dm_read       = 1'b0;
    bus.dm_write      = 1'b0;
    bus.dm_addr       = '0;
    bus.dm_write_data = '0;
    if (!rst) begin
      bus.stall = flush_act || (store && full);
      if (load) bus.read_data = hit ? hit_data : bus.dm_read_data;
      if (ld_miss) begin
        bus.dm_read = 1'b1;
        bus.dm_addr = bus.addr;
      end else if (drain) begin
        bus.dm_write      = 1'b1;
        bus.dm_addr       = addr_q[head_q];
        bus.dm_write_data = data_q[head_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      case (state_q)
        EMPTY:    if (enq) state_q <= ACTIVE;
        ACTIVE: begin
          if (flush_act)           state_q <= (count_d == '0) ? EMPTY : FLUSHING;
          else if (count_d == '0)  state_q <= EMPTY;
        end
        FLUSHING: if (count_d == '0) state_q <= EMPTY;
        default:  state_q <= EMPTY;
      endcase
    end
  end

  // Payload needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.addr;
      data_q[tail_q] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded bench: a queue-based reference model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
import store_buffer_pkg::*;

module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [31:0] rdata;
    logic        stall;
    logic        dmr;
    logic        dmw;
    logic [31:0] dma;
    logic [31:0] dmwd;
    int          cnt;
    int          st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ent_t m_q[$];
  bit   m_flush = 1'b0;
  exp_t exp_q[$];

  store_buffer_if #(.DATA_W(DATA_W)) sb();

  store_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, want);
    end
  endtask

  // Drive one cycle, predict its outputs from the model, then advance the model.
  task automatic step(input bit r, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd, input bit fl);
    exp_t        e;
    bit          hit, port, fa;
    logic [31:0] hd;
    rst              = r;
    sb.mem_read      = rd;
    sb.mem_write     = wr;
    sb.addr          = a;
    sb.write_data    = wd;
    sb.flush         = fl;
    sb.dm_read_data  = $urandom();
    e.rdata = '0; e.stall = 0; e.dmr = 0; e.dmw = 0; e.dma = '0; e.dmwd = '0;
    e.cnt = m_q.size();
    e.st  = m_flush ? int'(FLUSHING) : (m_q.size() != 0 ? int'(ACTIVE) : int'(EMPTY));
    if (r) begin
      m_q.delete();
      m_flush = 1'b0;
    end else begin
      fa   = m_flush || (fl && m_q.size() > 0);
      port = 1'b0;
      if (fa) e.stall = 1'b1;
      else begin
        e.stall = wr && (m_q.size() == DEPTH);
        if (rd) begin
          hit = 1'b0;
          hd  = '0;
          for (int i = m_q.size() - 1; i >= 0; i--)
            if (!hit && m_q[i].a == a) begin hit = 1'b1; hd = m_q[i].d; end
          if (hit) e.rdata = hd;
          else begin
            e.rdata = sb.dm_read_data;
            e.dmr   = 1'b1;
            e.dma   = a;
            port    = 1'b1;
          end
        end
      end
      if (!port && m_q.size() > 0) begin
        e.dmw  = 1'b1;
        e.dma  = m_q[0].a;
        e.dmwd = m_q[0].d;
      end
      if (!fa && wr && m_q.size() < DEPTH) m_q.push_back('{a: a, d: wd});
      if (e.dmw) void'(m_q.pop_front());
      m_flush = fa && (m_q.size() > 0);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 32'h0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("read_data",     sb.read_data,          e.rdata);
        chk("stall",         32'(sb.stall),         32'(e.stall));
        chk("dm_read",       32'(sb.dm_read),       32'(e.dmr));
        chk("dm_write",      32'(sb.dm_write),      32'(e.dmw));
        chk("dm_addr",       sb.dm_addr,            e.dma);
        chk("dm_write_data", sb.dm_write_data,      e.dmwd);
        chk("count",         32'(dut.count_q),      32'(e.cnt));
        chk("state",         32'(dut.state_q),      32'(e.st));
      end
    end
  end

  initial begin : stim
    sb.mem_read = 0; sb.mem_write = 0; sb.addr = '0; sb.write_data = '0;
    sb.flush = 0; sb.dm_read_data = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h40, 32'h5, 1);
    // single store then drain
    step(0, 0, 1, 32'h4, 32'hDEAD_BEEF, 0);
    idle(3);
    // youngest-match forwarding
    step(0, 0, 1, 32'h8, 32'h11, 0);
    step(0, 0, 1, 32'h8, 32'h22, 0);
    step(0, 1, 0, 32'h8, 32'h0, 0);
    idle(3);
    // fill behind missing loads, stall on fifth, retry after one drain
    for (int i = 0; i < 5; i++) step(0, 1, 1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 0);
    step(0, 0, 1, 32'h110, 32'hA4, 0);
    step(0, 0, 1, 32'h110, 32'hA4, 0);
    idle(6);
    // missing load with two pending
    step(0, 1, 1, 32'h200, 32'h1, 0);
    step(0, 1, 1, 32'h204, 32'h2, 0);
    step(0, 1, 0, 32'h10, 32'h0, 0);
    idle(3);
    // flush of three entries, with ignored traffic during it
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h300 + 32'(i * 4), 32'hC0 + 32'(i), 0);
    step(0, 1, 1, 32'h300, 32'hFF, 1);
    step(0, 1, 1, 32'h304, 32'hFE, 0);
    step(0, 1, 0, 32'h308, 32'h0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1);
    // reset with three pending
    for (int i = 0; i < 3; i++) step(0, 1, 1, 32'h400 + 32'(i * 4), 32'hE0 + 32'(i), 0);
    step(1, 0, 0, 0, 0, 0);
    idle(4);
    // randomized traffic over a small address set so forwarding hits often
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           32'($urandom_range(0, 7)) << 2,
           $urandom(),
           $urandom_range(0, 15) == 0);
    end
    idle(8);
    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, is the number of buffered stores (power of two, at least 2).
REQ-002 Parameter DATA_W, default 32, is the data and address width.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port mem_read, input, 1 bit: CPU load request this cycle.
REQ-006 Port mem_write, input, 1 bit: CPU store request this cycle.
REQ-007 Port addr, input, DATA_W bits: CPU load/store address (CPU alu_out).
REQ-008 Port write_data, input, DATA_W bits: CPU store data (CPU reg_file_out_2).
REQ-009 Port flush, input, 1 bit: drain-all request.
REQ-010 Port read_data, output, DATA_W bits: load result returned to the CPU (CPU data_mem_out).
REQ-011 Port stall, output, 1 bit: CPU must hold its current instruction.
REQ-012 Port dm_read, output, 1 bit: data_mem read strobe.
REQ-013 Port dm_write, output, 1 bit: data_mem write strobe.
REQ-014 Port dm_addr, output, DATA_W bits: data_mem address.
REQ-015 Port dm_write_data, output, DATA_W bits: data_mem write data.
REQ-016 Port dm_read_data, input, DATA_W bits: data_mem combinational read data.

Function
REQ-017 The block is a circular FIFO of DEPTH {addr, data} entries with head/tail pointers and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-018 A store with count<DEPTH enqueues at tail on the clock edge, stall=0, zero-latency accept.
REQ-019 A store with count==DEPTH is not enqueued, stall=1 combinationally; the same-cycle drain frees one slot and the retried store is accepted next cycle.
REQ-020 A load whose addr matches a valid entry returns the youngest matching entry's data combinationally, dm_read=0, and the drain proceeds in that cycle.
REQ-021 A load with no match drives dm_read=1, dm_addr=addr, read_data=dm_read_data the same cycle, and suppresses the drain for that cycle (the load owns the port).
REQ-022 Drain: when the port is free and count>0, drive dm_write=1 with the head entry and advance head at the edge; at most one drain per cycle.
REQ-023 Simultaneous enqueue and drain leaves count unchanged; both pointers advance.
REQ-024 mem_read and mem_write high together: the store is handled per REQ-018/019; read_data is forwarded per REQ-020/021 using the pre-enqueue contents.
REQ-025 With no load, read_data=0; with no port owner, dm_read=dm_write=0 and dm_addr=dm_write_data=0.
REQ-026 FSM states: EMPTY (count==0), ACTIVE (count>0), FLUSHING.
REQ-027 Transitions: EMPTY->ACTIVE on enqueue; ACTIVE->EMPTY when the last entry drains with no enqueue; EMPTY/ACTIVE->FLUSHING on flush=1 with count>0; FLUSHING->EMPTY when count reaches 0.
REQ-028 In FLUSHING, stall=1, new stores and loads are ignored, and one entry drains per cycle.
REQ-029 flush=1 with count==0 has no effect (stall=0).

Reset
REQ-030 rst=1 at an edge clears head, tail, count and all valid bits and sets state EMPTY, discarding buffered stores even mid-drain or mid-flush.
REQ-031 While rst=1 and after reset, stall=0, dm_read=0, dm_write=0 and all data/address outputs are 0.

Structure
REQ-032 Package store_buffer_pkg holds the state enum (EMPTY, ACTIVE, FLUSHING) and the DEPTH/DATA_W defaults.
REQ-033 Sub-module store_buffer_match is the youngest-first address comparator and priority select (hit flag plus data) over all entries.

Verification
REQ-034 Store 0x0000_0004<-0xDEAD_BEEF, then idle: dm_write=1 with that address and data in the next cycle, count returns to 0, state EMPTY.
REQ-035 Store addr 8<-0x11, then addr 8<-0x22 on consecutive cycles, then load addr 8 with the buffer non-empty: read_data=0x22 and dm_read=0.
REQ-036 Five back-to-back stores with DEPTH=4 and loads to other addresses holding the port: stall=1 on the fifth store; accepted the cycle after one drain; all five reach memory in order.
REQ-037 Load addr 0x10 missing while 2 entries are pending: dm_read=1, read_data=dm_read_data, no drain that cycle, count still 2.
REQ-038 Three stores then flush=1: stall=1 for 3 cycles, 3 dm_write pulses in FIFO order, state EMPTY, then stall=0.
REQ-039 rst=1 with 3 entries pending: next cycle count=0, dm_write=0, and no buffered data reaches memory afterwards.
